spike_rate_decoder: RTL and testbench
=====================================

# spike_rate_decoder

Receive-side counterpart to the LIF neuron: consumes the neuron's one-bit spike stream and decodes it back into numeric values. Two values are produced:
- a per-window spike count (rate code), delivered over a valid/ready handshake;
- the inter-spike interval (ISI) in clock cycles.

Sits between the `lif` spike output and downstream readout logic or the pad mux.

## Interface
- `WIDTH`, 8: width of the rate result; count saturates at 2^WIDTH-1.
- `WINDOW_LOG2`, 4: window length is 2^WINDOW_LOG2 cycles.
- `ISI_W`, 8: width of the ISI result; saturates at 2^ISI_W-1.

- `clk` input 1: single clock, rising edge.
- `reset` input 1: synchronous, active-high.
- `spike` input 1: spike stream; every cycle sampled high counts as one spike.
- `out_ready` input 1: downstream accepts `rate` when high together with `out_valid`.
- `out_valid` output 1: `rate` holds an unaccepted result.
- `rate` output WIDTH: spike count of the last completed window.
- `isi_valid` output 1: one-cycle pulse when `isi` updates.
- `isi` output ISI_W: cycles between the two most recent spikes.
- `overrun` output 1: sticky; a window result was dropped.

## Operation
- **Window counter** `win_cnt`:
  - Counts 0 .. 2^WINDOW_LOG2-1 and wraps; free-running from reset.
  - The last cycle is the one with `win_cnt` = max.
- **Spike counter** `sp_cnt`:
  - Increments (saturating) on every `spike`=1 cycle.
  - On the last window cycle, result = sat(`sp_cnt` + `spike`), so a spike on the final cycle belongs to the ending window.
  - `sp_cnt` restarts at 0 on the next cycle.
- **Result delivery** (decided on the last window cycle):
  - If the output register is free (`out_valid`=0, or `out_valid`&&`out_ready` this cycle), load the result and set `out_valid`.
  - Otherwise drop the result, keep the held value, and set `overrun`.
  - `overrun` is cleared only by `reset`.
- **Handshake**:
  - A transfer occurs when `out_valid`&&`out_ready`.
  - `rate` is stable while `out_valid`&&!`out_ready`.
  - After a transfer without a new load, `out_valid` drops the next cycle.
- **ISI FSM**:
  - IDLE: no spike seen since reset.
    - `spike` → MEASURE with `isi_cnt`<=1; no `isi_valid` pulse.
  - MEASURE: `isi_cnt` counts cycles since the previous spike.
    - On `spike`: `isi`<=`isi_cnt`, `isi_valid`<=1, `isi_cnt`<=1.
    - Otherwise: `isi_cnt`<=sat(`isi_cnt`+1).
  - Spikes on consecutive cycles give `isi`=1; spikes N cycles apart give `isi`=N.
  - A saturated value means "≥ 2^ISI_W-1".
- **Arithmetic**: unsigned throughout; all counters saturate, never wrap. The window counter is the exception and wraps by design.

## Timing
- **Reset values**: `out_valid`=0, `rate`=0, `isi_valid`=0, `isi`=0, `overrun`=0, FSM=IDLE, `win_cnt`=0, `sp_cnt`=0.
- **Reset mid-window**: the partial count is discarded; the first full window starts the cycle after `reset` deasserts.
- **Rate latency**: `rate`/`out_valid` are registered and appear 1 cycle after the last window cycle.
  - Window k (cycles 16k..16k+15 at defaults) is visible at cycle 16k+16.
- **ISI latency**: `isi`/`isi_valid` appear 1 cycle after the spike that closes the interval.
- **Simultaneous load and accept**: on the last window cycle with `out_valid`&&`out_ready`, the old value transfers and the new value loads. `out_valid` stays 1 and no overrun is flagged.
- **Throughput**: one rate result per window, one ISI result per spike; no backpressure on `spike`.

## Structure
- **Package** `spike_dec_pkg`:
  - ISI FSM state enum (`ISI_IDLE`, `ISI_MEASURE`).
  - Saturating-increment function, parameterised by width.
- **Sub-module** `spike_isi_timer`: ISI FSM plus `isi_cnt`, outputs `isi`/`isi_valid`.
- **Top level**: window counter, spike counter, output register/handshake and overrun flag.

## Test plan
All scenarios use the defaults (`WIDTH`=8, `WINDOW_LOG2`=4, `ISI_W`=8) unless stated.
1. `spike`=1 constantly from reset release, `out_ready`=1 → `out_valid` pulses at cycle 16 with `rate`=16, repeating every 16 cycles. Rerun with `WIDTH`=4 → `rate`=15 (saturated).
2. Spikes at cycles 0,4,8,12,… → `rate`=4 per window. First `isi_valid` at cycle 5 with `isi`=4, then every 4 cycles with `isi`=4.
3. `out_ready`=0 for 40 cycles with 3 spikes per window:
   - first result held stable with `rate`=3, second dropped, `overrun`=1;
   - raise `out_ready` → exactly one transfer of 3, then `overrun` stays 1.
4. Spike at cycle 0, silence for 300 cycles, spike at cycle 301 → single `isi_valid` with `isi`=255. A spike at cycle 302 → `isi`=1.
5. Five spikes, then `reset` at window cycle 9 → all outputs 0 and FSM=IDLE. The next window after release reports only post-reset spikes, and the first post-reset spike gives no `isi_valid`.
6. Spike only on window cycle 15 while `out_valid`=1 and `out_ready`=1 → old result transfers, `rate`=1 loads next cycle, `out_valid` remains 1, `overrun`=0.

Source files
------------

// File: rtl/spike_rate_decoder_pkg.sv
// spike_dec_pkg: shared ISI state encoding and saturating increment for the spike decoder
package spike_dec_pkg;
  typedef enum logic {ISI_IDLE, ISI_MEASURE} isi_state_e;
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] mx;
    mx = (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    return (v >= mx) ? mx : v + 32'd1;
  endfunction
endpackage

// File: rtl/spike_rate_decoder_if.sv
// spike_rate_decoder_if: rate handshake and ISI result bundle of the spike decoder
interface spike_rate_decoder_if #(parameter int WIDTH = 8, parameter int ISI_W = 8);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] rate;
  logic             isi_valid;
  logic [ISI_W-1:0] isi;
  logic             overrun;
  modport master(output out_valid, rate, isi_valid, isi, overrun, input out_ready);
  modport slave(input out_valid, rate, isi_valid, isi, overrun, output out_ready);
endinterface

// File: rtl/spike_isi_timer.sv
// spike_isi_timer: measures cycles between consecutive spikes, saturating at 2^ISI_W-1
module spike_isi_timer
  import spike_dec_pkg::*;
#(parameter int ISI_W = 8) (
  input  logic             clk,
  input  logic             reset,
  input  logic             spike_i,
  output logic [ISI_W-1:0] isi_o,
  output logic             isi_valid_o
);
  isi_state_e       state_q, state_d;
  logic [ISI_W-1:0] cnt_q, cnt_d, isi_q, isi_d;
  logic             valid_q, valid_d;
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ISI_IDLE;
      cnt_q   <= '0;
      isi_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isi_q   <= isi_d;
      valid_q <= valid_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isi_d   = isi_q;
    valid_d = 1'b0;
    if (state_q == ISI_IDLE) begin
      if (spike_i) begin
        state_d = ISI_MEASURE;
        cnt_d   = ISI_W'(1);
      end
    end else if (spike_i) begin
      isi_d   = cnt_q;
      valid_d = 1'b1;
      cnt_d   = ISI_W'(1);
    end else begin
      cnt_d = ISI_W'(sat_inc(32'(cnt_q), ISI_W));
    end
  end
  assign isi_o       = isi_q;
  assign isi_valid_o = valid_q;
endmodule

// File: rtl/spike_rate_decoder.sv
// spike_rate_decoder: decodes a spike stream into per-window counts (valid/ready) and inter-spike intervals
module spike_rate_decoder
  import spike_dec_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int WINDOW_LOG2 = 4,
  parameter int ISI_W       = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 spike,
  spike_rate_decoder_if.master dec
);
  logic [WINDOW_LOG2-1:0] win_cnt_q;
  logic [WIDTH-1:0]       sp_cnt_q, sp_cnt_d, sp_sum, rate_q, rate_d;
  logic                   out_valid_q, out_valid_d, overrun_q, overrun_d;
  logic                   last, xfer, load;
  always_comb begin
    last        = &win_cnt_q;
    sp_sum      = spike ? WIDTH'(sat_inc(32'(sp_cnt_q), WIDTH)) : sp_cnt_q;
    sp_cnt_d    = last ? '0 : sp_sum;
    xfer        = out_valid_q && dec.out_ready;
    load        = last && (!out_valid_q || xfer);
    out_valid_d = load ? 1'b1 : (xfer ? 1'b0 : out_valid_q);
    rate_d      = load ? sp_sum : rate_q;
    // a window ending while the held result is still unaccepted is lost for good
    overrun_d   = overrun_q || (last && !load);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      win_cnt_q   <= '0;
      sp_cnt_q    <= '0;
      rate_q      <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      win_cnt_q   <= win_cnt_q + 1'b1;
      sp_cnt_q    <= sp_cnt_d;
      rate_q      <= rate_d;
      out_valid_q <= out_valid_d;
      overrun_q   <= overrun_d;
    end
  end
  assign dec.out_valid = out_valid_q;
  assign dec.rate      = rate_q;
  assign dec.overrun   = overrun_q;
  spike_isi_timer #(.ISI_W(ISI_W)) u_isi (
    .clk        (clk),
    .reset      (reset),
    .spike_i    (spike),
    .isi_o      (dec.isi),
    .isi_valid_o(dec.isi_valid)
  );
endmodule

// File: tb/tb_spike_rate_decoder.sv
// tb_spike_rate_decoder: directed scenarios checked against a cycle-count model of the decoder
module tb_spike_rate_decoder;
  logic clk = 0, reset = 1, spike = 0, out_ready = 0;
  int   checks = 0, errors = 0;
  always #5 clk = ~clk;

  spike_rate_decoder_if #(.WIDTH(8), .ISI_W(8)) d8 ();
  spike_rate_decoder_if #(.WIDTH(4), .ISI_W(8)) d4 ();
  assign d8.out_ready = out_ready;
  assign d4.out_ready = out_ready;
  spike_rate_decoder #(.WIDTH(8), .WINDOW_LOG2(4), .ISI_W(8)) dut (.clk(clk), .reset(reset), .spike(spike), .dec(d8));
  spike_rate_decoder #(.WIDTH(4), .WINDOW_LOG2(4), .ISI_W(8)) dut4 (.clk(clk), .reset(reset), .spike(spike), .dec(d4));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // model: cycles since reset, raw spikes per window, last spike time
  int m_t, m_cnt, m_raw, m_last, m_isi;
  bit m_valid, m_over, m_isiv;
  always @(posedge clk) begin
    if (reset) begin
      m_t <= 0; m_cnt <= 0; m_raw <= 0; m_last <= -1; m_isi <= 0;
      m_valid <= 0; m_over <= 0; m_isiv <= 0;
    end else begin
      m_t <= m_t + 1;
      if (m_t % 16 == 15) begin
        m_cnt <= 0;
        if (!m_valid || out_ready) begin
          m_valid <= 1;
          m_raw   <= m_cnt + int'(spike);
        end else m_over <= 1;
      end else begin
        m_cnt <= m_cnt + int'(spike);
        if (m_valid && out_ready) m_valid <= 0;
      end
      m_isiv <= 0;
      if (spike) begin
        m_last <= m_t;
        if (m_last >= 0) begin
          m_isiv <= 1;
          m_isi  <= (m_t - m_last > 255) ? 255 : m_t - m_last;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("out_valid", int'(d8.out_valid), int'(m_valid));
    chk("rate", int'(d8.rate), m_raw > 255 ? 255 : m_raw);
    chk("rate_w4", int'(d4.rate), m_raw > 15 ? 15 : m_raw);
    chk("overrun", int'(d8.overrun), int'(m_over));
    chk("isi_valid", int'(d8.isi_valid), int'(m_isiv));
    chk("isi", int'(d8.isi), m_isi);
  end

  task automatic cyc(input logic s, input logic r);
    spike = s; out_ready = r;
    @(posedge clk); #1;
  endtask
  task automatic do_reset();
    reset = 1; spike = 0;
    @(posedge clk); #1;
    reset = 0;
  endtask

  initial begin
    repeat (2) @(posedge clk); #1;
    reset = 0;
    chk("rst_valid", int'(d8.out_valid), 0);
    chk("rst_rate", int'(d8.rate), 0);
    chk("rst_isi", int'(d8.isi), 0);
    // 1: spike every cycle
    for (int c = 0; c < 48; c++) begin
      cyc(1, 1);
      if (c == 1) chk("s1_isi1", int'(d8.isi), 1);
      if (c == 15) begin
        chk("s1_valid16", int'(d8.out_valid), 1);
        chk("s1_rate16", int'(d8.rate), 16);
        chk("s1_rate_sat", int'(d4.rate), 15);
      end
      if (c == 16) chk("s1_drop", int'(d8.out_valid), 0);
    end
    // 2: spike every 4 cycles
    do_reset();
    for (int c = 0; c < 32; c++) begin
      cyc(c % 4 == 0, 1);
      if (c == 3) chk("s2_noisi", int'(d8.isi_valid), 0);
      if (c == 4) begin
        chk("s2_isiv", int'(d8.isi_valid), 1);
        chk("s2_isi4", int'(d8.isi), 4);
      end
      if (c == 15) chk("s2_rate4", int'(d8.rate), 4);
    end
    // 3: backpressure, 3 spikes per window
    do_reset();
    for (int c = 0; c < 56; c++) begin
      cyc(c % 16 == 0 || c % 16 == 5 || c % 16 == 10, c >= 40);
      if (c == 15) chk("s3_rate3", int'(d8.rate), 3);
      if (c == 31) begin
        chk("s3_over", int'(d8.overrun), 1);
        chk("s3_held", int'(d8.rate), 3);
      end
      if (c == 40) begin
        chk("s3_xfer", int'(d8.out_valid), 0);
        chk("s3_sticky", int'(d8.overrun), 1);
      end
    end
    // 4: long silence saturates isi
    do_reset();
    for (int c = 0; c < 304; c++) begin
      cyc(c == 0 || c == 301 || c == 302, 1);
      if (c == 301) begin
        chk("s4_isiv", int'(d8.isi_valid), 1);
        chk("s4_isi_sat", int'(d8.isi), 255);
      end
      if (c == 302) chk("s4_isi1", int'(d8.isi), 1);
    end
    // 5: reset mid-window
    do_reset();
    for (int c = 0; c < 9; c++) cyc(c % 2 == 0, 1);
    do_reset();
    chk("s5_isi0", int'(d8.isi), 0);
    chk("s5_valid0", int'(d8.out_valid), 0);
    for (int c = 0; c < 20; c++) begin
      cyc(c == 3 || c == 7, 1);
      if (c == 3) chk("s5_noisi", int'(d8.isi_valid), 0);
      if (c == 15) chk("s5_rate2", int'(d8.rate), 2);
    end
    // 6: simultaneous accept and load
    do_reset();
    for (int c = 0; c < 34; c++) begin
      cyc(c < 3 || c == 31, c < 16 || c == 31);
      if (c == 31) begin
        chk("s6_valid", int'(d8.out_valid), 1);
        chk("s6_rate1", int'(d8.rate), 1);
        chk("s6_noover", int'(d8.overrun), 0);
      end
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
